accumulator_8: RTL and testbench

//  Accumulator register on the SAP data bus: the consumer side of the ALU result path.

---
 rtl/accumulator_8.sv | 106 ++++++++++
 tb/tb_accumulator_8.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_8.sv
// accumulator_8
//   Accumulator register on the SAP data bus. It loads from the shared bus
//   and always presents its contents to the adder/subtractor as operand A.
//   It runs single-cycle accumulator ops and keeps the zero, sign and carry
//   flags. It drives its contents back onto the bus through a tri-state
//   buffer that has an active-low enable.
//
// Parameters
//   WIDTH      data/bus width in bits
//   RESET_VAL  accumulator value while clr_n is low
//
// Ports
//   clk       in     system clock; all state changes on the rising edge
//   clr_n     in     asynchronous, active-low clear
//   bus       inout  shared data bus
//   op        in     accumulator operation, sampled on the rising edge
//   out_en_n  in     active-low bus drive enable (combinational)
//   acc       out    current accumulator value (never tri-stated)
//   flag_z    out    zero flag
//   flag_s    out    sign flag
//   flag_cy   out    carry flag
module accumulator_8 #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic [2:0]       op,
  input  logic             out_en_n,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_cy
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INR  = 3'b010;
  localparam logic [2:0] OP_DCR  = 3'b011;
  localparam logic [2:0] OP_RAL  = 3'b100;
  localparam logic [2:0] OP_RAR  = 3'b101;
  localparam logic [2:0] OP_CMA  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             z_q, z_d;
  logic             s_q, s_d;
  logic             cy_q, cy_d;
  logic             upd_zs;

  always_comb begin
    acc_d  = acc_q;
    z_d    = z_q;
    s_d    = s_q;
    cy_d   = cy_q;
    upd_zs = 1'b0;
    case (op)
      OP_HOLD: ;
      // When this block is also driving the bus, bus equals acc_q.
      // The load therefore reads back its own value and stays defined.
      OP_LOAD: begin acc_d = bus;                  upd_zs = 1'b1; end
      OP_INR:  begin acc_d = acc_q + WIDTH'(1);    upd_zs = 1'b1; end
      OP_DCR:  begin acc_d = acc_q - WIDTH'(1);    upd_zs = 1'b1; end
      OP_RAL:  {cy_d, acc_d} = {acc_q, cy_q};
      OP_RAR:  {acc_d, cy_d} = {cy_q, acc_q};
      OP_CMA:  begin acc_d = ~acc_q;               upd_zs = 1'b1; end
      OP_CLR:  begin acc_d = '0; cy_d = 1'b0;      upd_zs = 1'b1; end
      // An unknown op poisons all state. It is not treated as HOLD, so a
      // broken control word is visible in simulation.
      default: begin
        acc_d = 'x;
        z_d   = 1'bx;
        s_d   = 1'bx;
        cy_d  = 1'bx;
      end
    endcase
    if (upd_zs) begin
      z_d = (acc_d == '0);
      s_d = acc_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_q <= RESET_VAL;
      z_q   <= 1'b1;
      s_q   <= 1'b0;
      cy_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
      s_q   <= s_d;
      cy_q  <= cy_d;
    end
  end

  assign acc     = acc_q;
  assign flag_z  = z_q;
  assign flag_s  = s_q;
  assign flag_cy = cy_q;

  // The bus driver follows out_en_n even while clr_n is held low.
  assign bus = out_en_n ? {WIDTH{1'bz}} : acc_q;

endmodule

// File: tb/tb_accumulator_8.sv
module tb_accumulator_8;

  logic       clk;
  logic       clr_n;
  wire  [7:0] bus;
  logic [2:0] op;
  logic       out_en_n;
  logic [7:0] acc;
  logic       flag_z, flag_s, flag_cy;

  logic       tb_drv;
  logic [7:0] tb_bus;
  assign bus = tb_drv ? tb_bus : 8'bz;

  int tests_run = 0;
  int failed    = 0;

  // Reference state, kept as plain integers.
  int macc;
  int mz, ms, mcy;

  accumulator_8 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .bus      (bus),
    .op       (op),
    .out_en_n (out_en_n),
    .acc      (acc),
    .flag_z   (flag_z),
    .flag_s   (flag_s),
    .flag_cy  (flag_cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    macc = 0; mz = 1; ms = 0; mcy = 0;
  endtask

  task automatic model_op(input int o, input int busv);
    int t;
    case (o)
      1: begin macc = busv;               mz = (macc == 0); ms = macc / 128; end
      2: begin macc = (macc + 1) % 256;   mz = (macc == 0); ms = macc / 128; end
      3: begin macc = (macc + 255) % 256; mz = (macc == 0); ms = macc / 128; end
      4: begin t = macc * 2 + mcy; mcy = t / 256; macc = t % 256; end
      5: begin t = macc % 2; macc = macc / 2 + mcy * 128; mcy = t; end
      6: begin macc = 255 - macc;         mz = (macc == 0); ms = macc / 128; end
      7: begin macc = 0; mz = 1; ms = 0; mcy = 0; end
      default: ;
    endcase
  endtask

  // Drives one op for a single cycle. The bench drives the bus whenever the
  // DUT does not, so a LOAD never samples a floating bus.
  task automatic step(input logic [2:0] o, input logic [7:0] v, input logic oe_n);
    int busv;
    op       = o;
    out_en_n = oe_n;
    tb_drv   = oe_n;
    tb_bus   = v;
    busv     = oe_n ? int'(v) : macc;
    @(posedge clk);
    #1;
    model_op(int'(o), busv);
  endtask

  task automatic test_reset();
    clr_n = 1'b0; op = 3'd0; out_en_n = 1'b1; tb_drv = 1'b1; tb_bus = 8'h00;
    model_reset();
    #12;
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b100}) begin
      failed++;
      $display("FAIL reset_state got=%h z%b s%b cy%b exp=00 z1 s0 cy0", acc, flag_z, flag_s, flag_cy);
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    step(3'd0, 8'h00, 1'b1);
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b100}) begin
      failed++;
      $display("FAIL reset_release got=%h z%b s%b cy%b exp=00 z1 s0 cy0", acc, flag_z, flag_s, flag_cy);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_async_clear();
    step(3'd1, 8'h5A, 1'b1);
    tests_run++;
    if (acc !== 8'h5A) begin
      failed++;
      $display("FAIL load_5a got=%h exp=5a", acc);
    end
    // Put INR in flight, then clear mid-cycle. The clear must win before the next edge.
    op = 3'd2;
    #2 clr_n = 1'b0;
    #1;
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b100}) begin
      failed++;
      $display("FAIL async_clear got=%h z%b s%b cy%b exp=00 z1 s0 cy0", acc, flag_z, flag_s, flag_cy);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b100}) begin
      failed++;
      $display("FAIL clear_held got=%h z%b s%b cy%b exp=00 z1 s0 cy0", acc, flag_z, flag_s, flag_cy);
    end
    clr_n = 1'b1;
    model_reset();
    $display("[TB] test_async_clear done");
  endtask

  task automatic test_load_inr();
    step(3'd1, 8'h80, 1'b1);
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h80, 3'b010}) begin
      failed++;
      $display("FAIL load_80 got=%h z%b s%b cy%b exp=80 z0 s1 cy0", acc, flag_z, flag_s, flag_cy);
    end
    for (int i = 0; i < 128; i++) begin
      step(3'd2, 8'h00, 1'b1);
      tests_run++;
      if ({acc, flag_z, flag_s, flag_cy} !== {macc[7:0], mz[0], ms[0], mcy[0]}) begin
        failed++;
        $display("FAIL inr_%0d got=%h z%b s%b cy%b exp=%h z%0d s%0d cy%0d", i, acc, flag_z, flag_s, flag_cy, macc, mz, ms, mcy);
      end
    end
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b100}) begin
      failed++;
      $display("FAIL inr_wrap got=%h z%b s%b cy%b exp=00 z1 s0 cy0", acc, flag_z, flag_s, flag_cy);
    end
    $display("[TB] test_load_inr done");
  endtask

  task automatic test_dcr_wrap();
    step(3'd1, 8'h80, 1'b1);
    step(3'd4, 8'h00, 1'b1);   // RAL of 0x80 with CY=0 -> acc=00, CY=1, Z/S kept
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b011}) begin
      failed++;
      $display("FAIL ral_80 got=%h z%b s%b cy%b exp=00 z0 s1 cy1", acc, flag_z, flag_s, flag_cy);
    end
    step(3'd3, 8'h00, 1'b1);
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'hFF, 3'b011}) begin
      failed++;
      $display("FAIL dcr_wrap got=%h z%b s%b cy%b exp=ff z0 s1 cy1", acc, flag_z, flag_s, flag_cy);
    end
    $display("[TB] test_dcr_wrap done");
  endtask

  task automatic test_rotate();
    step(3'd7, 8'h00, 1'b1);
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'h00, 3'b100}) begin
      failed++;
      $display("FAIL clr got=%h z%b s%b cy%b exp=00 z1 s0 cy0", acc, flag_z, flag_s, flag_cy);
    end
    step(3'd1, 8'h81, 1'b1);
    step(3'd4, 8'h00, 1'b1);
    tests_run++;
    if ({acc, flag_cy} !== {8'h02, 1'b1}) begin
      failed++;
      $display("FAIL ral_81 got=%h cy%b exp=02 cy1", acc, flag_cy);
    end
    step(3'd5, 8'h00, 1'b1);
    tests_run++;
    if ({acc, flag_cy} !== {8'h81, 1'b0}) begin
      failed++;
      $display("FAIL rar_back got=%h cy%b exp=81 cy0", acc, flag_cy);
    end
    $display("[TB] test_rotate done");
  endtask

  task automatic test_bus_drive();
    step(3'd1, 8'h3C, 1'b1);
    op = 3'd0; tb_drv = 1'b0; out_en_n = 1'b0;
    #1;
    tests_run++;
    if (bus !== 8'h3C) begin
      failed++;
      $display("FAIL bus_drive got=%h exp=3c", bus);
    end
    // With the enable released, the bench's own value must come through uncontended.
    out_en_n = 1'b1; tb_bus = 8'hA5; tb_drv = 1'b1;
    #1;
    tests_run++;
    if (bus !== 8'hA5) begin
      failed++;
      $display("FAIL bus_release got=%h exp=a5", bus);
    end
    // The driver keeps following out_en_n while the clear is held.
    tb_drv = 1'b0; out_en_n = 1'b0; clr_n = 1'b0;
    #1;
    tests_run++;
    if (bus !== 8'h00) begin
      failed++;
      $display("FAIL bus_in_reset got=%h exp=00", bus);
    end
    out_en_n = 1'b1; tb_drv = 1'b1;
    @(posedge clk); #1;
    clr_n = 1'b1;
    model_reset();
    $display("[TB] test_bus_drive done");
  endtask

  task automatic test_self_load();
    step(3'd1, 8'h3C, 1'b1);
    step(3'd1, 8'hFF, 1'b0);
    tests_run++;
    if ({acc, flag_z, flag_s} !== {8'h3C, 2'b00}) begin
      failed++;
      $display("FAIL self_load got=%h z%b s%b exp=3c z0 s0", acc, flag_z, flag_s);
    end
    step(3'd6, 8'h00, 1'b1);
    tests_run++;
    if ({acc, flag_z, flag_s, flag_cy} !== {8'hC3, 2'b01, mcy[0]}) begin
      failed++;
      $display("FAIL cma got=%h z%b s%b cy%b exp=c3 z0 s1 cy%0d", acc, flag_z, flag_s, flag_cy, mcy);
    end
    $display("[TB] test_self_load done");
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [7:0] v;
    logic       oe;
    for (int i = 0; i < 300; i++) begin
      o  = 3'($urandom_range(0, 7));
      v  = 8'($urandom_range(0, 255));
      oe = 1'($urandom_range(0, 1));
      step(o, v, oe);
      tests_run++;
      if ({acc, flag_z, flag_s, flag_cy} !== {macc[7:0], mz[0], ms[0], mcy[0]}) begin
        failed++;
        $display("FAIL rand_%0d op=%0d v=%h oe_n=%b got=%h z%b s%b cy%b exp=%h z%0d s%0d cy%0d",
                 i, o, v, oe, acc, flag_z, flag_s, flag_cy, macc, mz, ms, mcy);
      end
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_load_inr();
    test_dcr_wrap();
    test_rotate();
    test_bus_drive();
    test_self_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
